// File: rtl/maze_pkg.sv
// Shared maze definitions: grid size, tile codes, sprite indices, direction encodings.
package maze_pkg;

    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WALL  = 2'd1,
        FOOD  = 2'd2,
        POWER = 2'd3
    } tile_t;

    localparam int PACMAN = 0;
    localparam int BLINKY = 1;
    localparam int PINKY  = 2;
    localparam int INKY   = 3;
    localparam int CLYDE  = 4;

    typedef enum logic [3:0] {
        RIGHT = 4'b0001,
        UP    = 4'b0010,
        DOWN  = 4'b0100,
        LEFT  = 4'b1000
    } dir_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            oob;
    } tag_t;

endpackage

// File: rtl/maze_lookup_arbiter_if.sv
// Request/response bus between the sprite movers and the maze lookup arbiter.
interface maze_lookup_arbiter_if
    import maze_pkg::*;
#(
    parameter int N_REQ  = 5,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 5,
    parameter int DATA_W = 2
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*COL_W-1:0] req_col;
    logic [N_REQ*ROW_W-1:0] req_row;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;

    modport master (
        output req_valid, req_col, req_row,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_col, req_row,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered pointer plus masked priority select (lowest index at/above ptr wins).
module rr_arbiter
    import maze_pkg::*;
#(
    parameter int N_REQ = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_valid
);

    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] masked;

    always_comb begin
        masked      = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            masked[i] = req[i] && (ID_W'(i) >= ptr);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx   = ID_W'(i);
                grant_valid = 1'b1;
            end
        end
        // Any request at or above ptr overrides the wrap-around choice.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_idx = ID_W'(i);
            end
        end
        grant = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/maze_lookup_arbiter.sv
// Shares the maze tile memory among the five sprite movers; returns tagged tile codes in grant order.
// Optional bounds check enabled by defining MAZE_ARB_OOB_CHECK_EN.
module maze_lookup_arbiter
    import maze_pkg::*;
#(
    parameter int N_REQ  = 5,
    parameter int COLS   = maze_pkg::COLS,
    parameter int ROWS   = maze_pkg::ROWS,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 5,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    maze_lookup_arbiter_if.slave  bus,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_data
);

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_valid;
    logic [COL_W-1:0]  sel_col;
    logic [ROW_W-1:0]  sel_row;
    logic [ADDR_W-1:0] addr_cur;
    logic              oob_cur;
    tag_t              tag_q [RD_LAT+1];

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = rst ? '0 : grant;

    always_comb begin
        sel_col = '0;
        sel_row = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_col = bus.req_col[i*COL_W +: COL_W];
                sel_row = bus.req_row[i*ROW_W +: ROW_W];
            end
        end
        addr_cur = ADDR_W'(32'(sel_row) * 32'(COLS) + 32'(sel_col));
`ifdef MAZE_ARB_OOB_CHECK_EN
        oob_cur = (32'(sel_col) >= 32'(COLS)) || (32'(sel_row) >= 32'(ROWS));
`else
        oob_cur = 1'b0;
`endif
    end

    // Tag stage k lines up with the read issued k cycles earlier; stage RD_LAT meets mem_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en        <= 1'b0;
            mem_addr      <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            for (int j = 0; j <= RD_LAT; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            mem_en   <= grant_valid && !oob_cur;
            mem_addr <= addr_cur;
            tag_q[0] <= '{valid: grant_valid, id: grant_idx, oob: oob_cur};
            for (int j = 1; j <= RD_LAT; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
            bus.rsp_valid <= tag_q[RD_LAT].valid ? (N_REQ'(1) << tag_q[RD_LAT].id) : '0;
            bus.rsp_id    <= tag_q[RD_LAT].valid ? tag_q[RD_LAT].id : '0;
            if (tag_q[RD_LAT].valid) begin
                bus.rsp_data <= tag_q[RD_LAT].oob ? DATA_W'(WALL) : mem_data;
            end else begin
                bus.rsp_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Scoreboard bench for maze_lookup_arbiter: RD_LAT=1 and RD_LAT=3 instances share one directed stimulus.
module tb_maze_lookup_arbiter;

    typedef struct {
        int id;
        int col;
        int row;
        int cyc;
        bit oob;
    } acc_t;

`ifdef MAZE_ARB_OOB_CHECK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_prev = 1'b0;
    logic [4:0]  req_valid_s = '0;
    logic [29:0] col_s = '0;
    logic [24:0] row_s = '0;
    logic [4:0]  ready_w [2];
    int          col_a [5];
    int          row_a [5];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          n_exp = 0;
    int          n_exp_mem = 0;
    acc_t        log_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic logic [1:0] rom(input logic [10:0] a);
        return 2'(a ^ (a >> 3));
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;
        maze_lookup_arbiter_if bus ();
        logic        mem_en;
        logic [10:0] mem_addr;
        logic [1:0]  mem_data;
        logic [1:0]  pipe [LAT];
        int          rd = 0;
        int          mrd = 0;
        int          rsp_cnt = 0;
        int          mem_cnt = 0;

        maze_lookup_arbiter #(.RD_LAT(LAT)) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .mem_en   (mem_en),
            .mem_addr (mem_addr),
            .mem_data (mem_data)
        );

        assign bus.req_valid = req_valid_s;
        assign bus.req_col   = col_s;
        assign bus.req_row   = row_s;
        assign ready_w[k]    = bus.req_ready;

        always @(posedge clk) begin
            pipe[0] <= rom(mem_addr);
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_data = pipe[LAT-1];

        always @(negedge clk) begin
            acc_t e;
            if (rst && rst_prev) begin
                check($sformatf("reset_mem_en_l%0d", LAT), int'(mem_en), 0);
                check($sformatf("reset_mem_addr_l%0d", LAT), int'(mem_addr), 0);
                check($sformatf("reset_rsp_valid_l%0d", LAT), int'(bus.rsp_valid), 0);
                check($sformatf("reset_rsp_id_l%0d", LAT), int'(bus.rsp_id), 0);
                check($sformatf("reset_rsp_data_l%0d", LAT), int'(bus.rsp_data), 0);
            end
            // Response side: the oldest outstanding accept is due LAT+2 cycles after acceptance.
            if (rd < log_q.size() && cyc >= log_q[rd].cyc + LAT + 2) begin
                e = log_q[rd];
                check($sformatf("rsp_valid_l%0d", LAT), int'(bus.rsp_valid), 1 << e.id);
                check($sformatf("rsp_id_l%0d", LAT), int'(bus.rsp_id), e.id);
                check($sformatf("rsp_data_l%0d", LAT), int'(bus.rsp_data),
                      e.oob ? 1 : int'(rom(11'(e.row * 40 + e.col))));
                check($sformatf("rsp_cycle_l%0d", LAT), cyc, e.cyc + LAT + 2);
                rd++;
                rsp_cnt++;
            end else if (bus.rsp_valid != '0) begin
                check($sformatf("rsp_unexpected_l%0d", LAT), int'(bus.rsp_valid), 0);
            end
            while (mrd < log_q.size() && log_q[mrd].oob) mrd++;
            if (mrd < log_q.size() && cyc >= log_q[mrd].cyc + 1) begin
                e = log_q[mrd];
                check($sformatf("mem_en_l%0d", LAT), int'(mem_en), 1);
                check($sformatf("mem_addr_l%0d", LAT), int'(mem_addr), (e.row * 40 + e.col) % 2048);
                mrd++;
                mem_cnt++;
            end else if (mem_en) begin
                check($sformatf("mem_unexpected_l%0d", LAT), int'(mem_en), 0);
            end
            if (rst) begin
                rd      = log_q.size();
                mrd     = log_q.size();
                rsp_cnt = 0;
                mem_cnt = 0;
            end
        end
    end

    task automatic step(input logic [4:0] v, input logic [4:0] exp_rdy);
        acc_t e;
        req_valid_s = v;
        for (int i = 0; i < 5; i++) begin
            col_s[i*6 +: 6] = 6'(col_a[i]);
            row_s[i*5 +: 5] = 5'(row_a[i]);
        end
        @(negedge clk);
        check("req_ready_l1", int'(ready_w[0]), int'(exp_rdy));
        check("req_ready_l3", int'(ready_w[1]), int'(exp_rdy));
        for (int i = 0; i < 5; i++) begin
            if (exp_rdy[i]) begin
                e.id  = i;
                e.col = col_a[i];
                e.row = row_a[i];
                e.cyc = cyc;
                e.oob = OOB_EN && (col_a[i] >= 40 || row_a[i] >= 30);
                log_q.push_back(e);
                n_exp++;
                if (!e.oob) n_exp_mem++;
            end
        end
        if (rst) begin
            n_exp     = 0;
            n_exp_mem = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'b00000, 5'b00000);
    endtask

    initial begin
        col_a = '{39, 0, 10, 39, 17};
        row_a = '{2, 0, 29, 29, 13};

        // Requests held high during reset must not be accepted.
        for (int i = 0; i < 3; i++) step(5'b11111, 5'b00000);
        rst = 1'b0;

        // Single pacman lookup at (39,2) -> address 119.
        step(5'b00001, 5'b00001);
        idle(6);

        // Move ptr to 0 via clyde, then full contention.
        step(5'b10000, 5'b10000);
        step(5'b11111, 5'b00001);
        step(5'b11111, 5'b00010);
        step(5'b11111, 5'b00100);
        step(5'b11111, 5'b01000);
        step(5'b11111, 5'b10000);
        step(5'b11111, 5'b00001);
        idle(6);

        // Fairness: ptr=1; grant 2, then 0 and 2 compete.
        step(5'b00100, 5'b00100);
        step(5'b00101, 5'b00001);
        step(5'b00101, 5'b00100);
        idle(6);

        // Out-of-range column and row.
        col_a[3] = 45; row_a[3] = 2;
        col_a[4] = 5;  row_a[4] = 31;
        step(5'b01000, 5'b01000);
        step(5'b10000, 5'b10000);
        idle(6);

        // Reset with two reads in flight and ptr=3 beforehand.
        col_a = '{3, 20, 7, 38, 1};
        row_a = '{4, 11, 0, 28, 27};
        step(5'b00010, 5'b00010);
        step(5'b00100, 5'b00100);
        rst = 1'b1;
        step(5'b11111, 5'b00000);
        rst = 1'b0;
        idle(8);

        // Pointer restarts at 0; back-to-back stream.
        step(5'b11111, 5'b00001);
        step(5'b11111, 5'b00010);
        step(5'b11111, 5'b00100);
        step(5'b11111, 5'b01000);
        step(5'b11111, 5'b10000);
        step(5'b00001, 5'b00001);
        step(5'b00001, 5'b00001);
        idle(10);

        check("rsp_count_l1", g[0].rsp_cnt, n_exp);
        check("rsp_count_l3", g[1].rsp_cnt, n_exp);
        check("mem_count_l1", g[0].mem_cnt, n_exp_mem);
        check("mem_count_l3", g[1].mem_cnt, n_exp_mem);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
